hazard_stall_unit: RTL and testbench

- Generates the ID-stage stall (IDStall) consumed by the ID/EX control-zeroing mux, plus PC and IF/ID write enables.
- Detects load-use and branch-operand hazards between the ID instruction and the EX/MEM instructions.
- Sequences multi-cycle stalls with a small FSM and keeps a saturating stall-cycle performance counter.

---
 rtl/hazard_stall_unit.sv | 137 +++++++++++++
 tb/tb_hazard_stall_unit.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_unit.sv
// rtl/hazard_stall_unit.sv - ID-stage load-use / branch-operand stall generator with stall counter
module hazard_stall_unit #(
   parameter int REG_AW = 5,
   parameter int CNT_W  = 32
) (
   input  logic              Clk,
   input  logic              Rst,
   input  logic [REG_AW-1:0] ID_Rs,
   input  logic [REG_AW-1:0] ID_Rt,
   input  logic              ID_UsesRs,
   input  logic              ID_UsesRt,
   input  logic              ID_Branch,
   input  logic [1:0]        EX_MemRead,
   input  logic              EX_RegWrite,
   input  logic [REG_AW-1:0] EX_WAddr,
   input  logic [1:0]        MEM_MemRead,
   input  logic [REG_AW-1:0] MEM_WAddr,
   input  logic              ExtStall,
   output logic              IDStall,
   output logic              PCWrite,
   output logic              IFIDWrite,
   output logic [CNT_W-1:0]  StallCycles
);

   typedef enum logic {
      RUN  = 1'b0,
      HOLD = 1'b1
   } state_t;

   state_t      state, state_nxt;
   logic [1:0]  remain, remain_nxt;
   logic        stall_raw;

   logic        match_ex;
   logic        match_mem;
   logic        h_lu;
   logic        h_bex;
   logic        h_bmem;
   logic [1:0]  need;

   // A destination matches when it is non-zero and an actually-read source names it.
   function automatic logic reg_match(
      input logic [REG_AW-1:0] a,
      input logic [REG_AW-1:0] rs,
      input logic [REG_AW-1:0] rt,
      input logic              use_rs,
      input logic              use_rt
   );
      return (a != '0) && ((use_rs && (rs == a)) || (use_rt && (rt == a)));
   endfunction

   // Hazard terms and the number of bubble cycles the worst one demands.
   always_comb begin
      match_ex  = reg_match(EX_WAddr,  ID_Rs, ID_Rt, ID_UsesRs, ID_UsesRt);
      match_mem = reg_match(MEM_WAddr, ID_Rs, ID_Rt, ID_UsesRs, ID_UsesRt);

      // Load in EX feeding the ID instruction; a branch in ID needs the data one stage earlier.
      h_lu   = (EX_MemRead != 2'b00) && match_ex;
      // ALU result in EX feeding a branch resolved in ID.
      h_bex  = ID_Branch && EX_RegWrite && (EX_MemRead == 2'b00) && match_ex;
      // Load in MEM feeding a branch resolved in ID.
      h_bmem = ID_Branch && (MEM_MemRead != 2'b00) && match_mem;

      need = 2'd0;
      if (h_lu || h_bex || h_bmem)
         need = 2'd1;
      if (h_lu && ID_Branch)
         need = 2'd2;
   end

   // Next-state and stall decode; HOLD with the count expired behaves exactly like RUN.
   always_comb begin
      state_nxt  = state;
      remain_nxt = remain;
      stall_raw  = 1'b0;
      case (state)
         RUN: begin
            stall_raw = (need != 2'd0) || ExtStall;
            if (need == 2'd2) begin
               state_nxt  = HOLD;
               remain_nxt = 2'd1;
            end
         end
         HOLD: begin
            if (remain != 2'd0) begin
               stall_raw  = 1'b1;
               remain_nxt = remain - 2'd1;
            end else begin
               // Count expired: re-evaluate hazards this cycle; ExtStall keeps us parked here.
               stall_raw = (need != 2'd0) || ExtStall;
               if (need == 2'd2) begin
                  state_nxt  = HOLD;
                  remain_nxt = 2'd1;
               end else if (ExtStall) begin
                  state_nxt  = HOLD;
                  remain_nxt = 2'd0;
               end else begin
                  state_nxt  = RUN;
                  remain_nxt = 2'd0;
               end
            end
         end
         default: begin
            state_nxt  = RUN;
            remain_nxt = 2'd0;
         end
      endcase
   end

   // Outputs are forced inactive while reset is held so no bubble leaks out of reset.
   always_comb begin
      IDStall   = Rst && stall_raw;
      PCWrite   = ~IDStall;
      IFIDWrite = ~IDStall;
   end

   // State register.
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         state  <= RUN;
         remain <= 2'd0;
      end else begin
         state  <= state_nxt;
         remain <= remain_nxt;
      end
   end

   // Saturating count of stalled cycles.
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         StallCycles <= '0;
      end else if (IDStall && (StallCycles != '1)) begin
         StallCycles <= StallCycles + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_hazard_stall_unit.sv
// tb/tb_hazard_stall_unit.sv - self-checking bench for hazard_stall_unit
module tb_hazard_stall_unit;

   logic        Clk = 1'b0;
   logic        Rst;
   logic [4:0]  ID_Rs, ID_Rt;
   logic        ID_UsesRs, ID_UsesRt, ID_Branch;
   logic [1:0]  EX_MemRead;
   logic        EX_RegWrite;
   logic [4:0]  EX_WAddr;
   logic [1:0]  MEM_MemRead;
   logic [4:0]  MEM_WAddr;
   logic        ExtStall;
   logic        IDStall, PCWrite, IFIDWrite;
   logic [31:0] StallCycles;
   logic        IDStall4, PCWrite4, IFIDWrite4;
   logic [3:0]  StallCycles4;

   int errors = 0;
   int checks = 0;

   int          m_owed;
   longint      m_cnt;
   int          m_cnt4;

   typedef struct {
      logic [4:0] rs, rt;
      logic       urs, urt, br;
      logic [1:0] exmr;
      logic       exrw;
      logic [4:0] exwa;
      logic [1:0] memmr;
      logic [4:0] memwa;
      logic       ext;
      logic       exp_stall;
      logic [31:0] exp_cnt;
   } vec_t;

   vec_t vecs[12];

   hazard_stall_unit dut (
      .Clk(Clk), .Rst(Rst), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt),
      .ID_UsesRs(ID_UsesRs), .ID_UsesRt(ID_UsesRt), .ID_Branch(ID_Branch),
      .EX_MemRead(EX_MemRead), .EX_RegWrite(EX_RegWrite), .EX_WAddr(EX_WAddr),
      .MEM_MemRead(MEM_MemRead), .MEM_WAddr(MEM_WAddr), .ExtStall(ExtStall),
      .IDStall(IDStall), .PCWrite(PCWrite), .IFIDWrite(IFIDWrite),
      .StallCycles(StallCycles)
   );

   hazard_stall_unit #(.REG_AW(5), .CNT_W(4)) dut4 (
      .Clk(Clk), .Rst(Rst), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt),
      .ID_UsesRs(ID_UsesRs), .ID_UsesRt(ID_UsesRt), .ID_Branch(ID_Branch),
      .EX_MemRead(EX_MemRead), .EX_RegWrite(EX_RegWrite), .EX_WAddr(EX_WAddr),
      .MEM_MemRead(MEM_MemRead), .MEM_WAddr(MEM_WAddr), .ExtStall(ExtStall),
      .IDStall(IDStall4), .PCWrite(PCWrite4), .IFIDWrite(IFIDWrite4),
      .StallCycles(StallCycles4)
   );

   always #5 Clk = ~Clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit hit(input logic [4:0] a);
      return (a != 0) && ((ID_UsesRs && ID_Rs == a) || (ID_UsesRt && ID_Rt == a));
   endfunction

   // Bubble cycles demanded by the current ID/EX/MEM mix: worst case wins.
   function automatic int need_f();
      int n = 0;
      if (ID_Branch && EX_RegWrite && EX_MemRead == 0 && hit(EX_WAddr)) n = 1;
      if (ID_Branch && MEM_MemRead != 0 && hit(MEM_WAddr)) n = 1;
      if (EX_MemRead != 0 && hit(EX_WAddr)) n = ID_Branch ? 2 : (n > 1 ? n : 1);
      return n;
   endfunction

   task automatic set_in(input logic [4:0] rs, input logic [4:0] rt, input logic urs,
                         input logic urt, input logic br, input logic [1:0] exmr,
                         input logic exrw, input logic [4:0] exwa, input logic [1:0] memmr,
                         input logic [4:0] memwa, input logic ext);
      ID_Rs = rs; ID_Rt = rt; ID_UsesRs = urs; ID_UsesRt = urt; ID_Branch = br;
      EX_MemRead = exmr; EX_RegWrite = exrw; EX_WAddr = exwa;
      MEM_MemRead = memmr; MEM_WAddr = memwa; ExtStall = ext;
   endtask

   task automatic clear_in();
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   // Called one time unit after a rising edge with inputs already driven.
   task automatic step();
      bit exp_stall;
      int n;
      #5;
      if (!Rst) begin
         m_owed = 0; m_cnt = 0; m_cnt4 = 0;
      end
      n = need_f();
      exp_stall = Rst && (m_owed > 0 || n > 0 || ExtStall);
      check("model_IDStall", IDStall, exp_stall);
      check("model_PCWrite", PCWrite, !exp_stall);
      check("model_IFIDWrite", IFIDWrite, !exp_stall);
      check("model_StallCycles", StallCycles, m_cnt);
      check("model_IDStall_w4", IDStall4, exp_stall);
      check("model_StallCycles_w4", StallCycles4, m_cnt4);
      @(posedge Clk);
      if (Rst) begin
         if (exp_stall) begin
            if (m_cnt < 64'hFFFF_FFFF) m_cnt++;
            if (m_cnt4 < 15) m_cnt4++;
         end
         if (m_owed > 0) m_owed--;
         else if (n == 2) m_owed = 1;
      end
      #1;
   endtask

   task automatic do_reset();
      clear_in();
      Rst = 1'b0;
      step();
      Rst = 1'b1;
   endtask

   initial begin
      // rs rt urs urt br exmr exrw exwa memmr memwa ext exp_stall exp_cnt
      vecs[0]  = '{8, 1, 1, 1, 0, 2, 1, 8, 0, 0, 0, 1, 1};  // lw $8 ; add $9,$8,$1
      vecs[1]  = '{8, 2, 1, 1, 1, 0, 1, 8, 0, 0, 0, 1, 1};  // add $8 ; beq $8,$2
      vecs[2]  = '{8, 2, 1, 1, 0, 0, 1, 8, 0, 0, 0, 0, 0};  // add $8 ; non-branch use
      vecs[3]  = '{0, 0, 1, 1, 0, 2, 1, 0, 0, 0, 0, 0, 0};  // lw $0 ; add $9,$0,$0
      vecs[4]  = '{8, 3, 0, 1, 0, 2, 1, 8, 0, 0, 0, 0, 0};  // Rs=8 but not read
      vecs[5]  = '{1, 8, 1, 1, 0, 1, 1, 8, 0, 0, 0, 1, 1};  // match through Rt
      vecs[6]  = '{5, 6, 1, 1, 1, 0, 0, 0, 2, 5, 0, 1, 1};  // MEM load ; branch
      vecs[7]  = '{5, 6, 1, 1, 0, 0, 0, 0, 2, 5, 0, 0, 0};  // MEM load ; non-branch
      vecs[8]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1};  // external hold only
      vecs[9]  = '{4, 6, 1, 1, 0, 2, 1, 7, 0, 0, 0, 0, 0};  // EX load, no match
      vecs[10] = '{8, 2, 1, 1, 0, 2, 1, 8, 0, 0, 1, 1, 1};  // load-use plus ExtStall: single
      vecs[11] = '{9, 2, 1, 1, 1, 0, 0, 9, 0, 0, 0, 0, 0};  // EX no RegWrite ; branch

      clear_in();
      Rst = 1'b0;
      @(posedge Clk);
      #1;
      check("reset_IDStall", IDStall, 0);
      check("reset_PCWrite", PCWrite, 1);
      check("reset_StallCycles", StallCycles, 0);

      foreach (vecs[i]) begin
         do_reset();
         set_in(vecs[i].rs, vecs[i].rt, vecs[i].urs, vecs[i].urt, vecs[i].br, vecs[i].exmr,
                vecs[i].exrw, vecs[i].exwa, vecs[i].memmr, vecs[i].memwa, vecs[i].ext);
         #2;
         check($sformatf("vec%0d_IDStall", i), IDStall, vecs[i].exp_stall);
         check($sformatf("vec%0d_PCWrite", i), PCWrite, !vecs[i].exp_stall);
         step();
         check($sformatf("vec%0d_StallCycles", i), StallCycles, vecs[i].exp_cnt);
      end

      // lw $8 in EX, beq $8,$2 in ID: two bubbles
      do_reset();
      set_in(8, 2, 1, 1, 1, 2, 1, 8, 0, 0, 0);
      #2; check("lub_c1_IDStall", IDStall, 1);
      step();
      set_in(8, 2, 1, 1, 1, 0, 0, 0, 2, 8, 0);
      #2; check("lub_c2_IDStall", IDStall, 1);
      step();
      clear_in();
      #2; check("lub_c3_IDStall", IDStall, 0);
      check("lub_StallCycles", StallCycles, 2);
      step();

      // ExtStall held three cycles inside HOLD
      do_reset();
      set_in(8, 2, 1, 1, 1, 2, 1, 8, 0, 0, 0);
      step();
      for (int c = 0; c < 3; c++) begin
         set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
         #2; check($sformatf("ext_hold%0d_IDStall", c), IDStall, 1);
         step();
      end
      clear_in();
      #2; check("ext_release_IDStall", IDStall, 0);
      check("ext_StallCycles", StallCycles, 4);
      step();

      // Reset dropped mid-HOLD with the hazard still present
      do_reset();
      set_in(8, 2, 1, 1, 1, 2, 1, 8, 0, 0, 0);
      step();
      Rst = 1'b0;
      #1;
      check("rst_hold_IDStall", IDStall, 0);
      check("rst_hold_PCWrite", PCWrite, 1);
      check("rst_hold_StallCycles", StallCycles, 0);
      step();
      Rst = 1'b1;
      clear_in();
      #2; check("rst_release_IDStall", IDStall, 0);
      step();

      // Saturation of the narrow counter
      do_reset();
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      for (int c = 0; c < 20; c++) step();
      check("sat_StallCycles_w4", StallCycles4, 15);
      check("sat_StallCycles_w32", StallCycles, 20);
      clear_in();
      step();

      // Randomised traffic against the reference model
      do_reset();
      for (int c = 0; c < 400; c++) begin
         Rst = ($urandom_range(0, 49) != 0);
         set_in($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1),
                $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 3),
                $urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 3), ($urandom_range(0, 5) == 0));
         step();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
